// File: rtl/param_simple_processor.sv
// Multi-cycle register/ALU processor: IDLE -> EXEC -> WB per instruction, DATA_W-bit datapath, NREG registers.
// Optional macro PROC_SHIFT_EN turns opcode 110 from XOR into SHL (Rx <= Rx << 1, C = old MSB).
module param_simple_processor #(
  parameter int DATA_W = 8,
  parameter int NREG   = 8,
  localparam int REG_AW = $clog2(NREG)
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [3+2*REG_AW-1:0]   func,
  input  logic [DATA_W-1:0]       dataIn,
  input  logic                    instrValid,
  output logic                    instrReady,
  output logic [DATA_W-1:0]       dataOut,
  output logic                    outValid,
  output logic                    zeroFlag,
  output logic                    carryFlag,
  output logic [1:0]              o_dbg_state
);

  // Handshake: an instruction transfers on a rising edge where instrValid and
  // instrReady are both high; instrReady is high only in IDLE, so func/dataIn
  // are sampled exactly once per instruction and ignored while busy.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_X110 = 3'b110;
  localparam logic [2:0] OP_OUT  = 3'b111;

  state_t              r_state;
  logic [DATA_W-1:0]   r_regs [NREG];
  logic [2:0]          r_op;
  logic [REG_AW-1:0]   r_rx;
  logic [REG_AW-1:0]   r_ry;
  logic [DATA_W-1:0]   r_imm;
  logic [DATA_W:0]     r_res;
  logic [DATA_W-1:0]   r_data_out;
  logic                r_out_valid;
  logic                r_zero;
  logic                r_carry;

  logic [DATA_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_b;
  logic [DATA_W:0]     w_res;

  assign w_a = r_regs[r_rx];
  assign w_b = r_regs[r_ry];

  // Bit DATA_W carries the carry (ADD), borrow (SUB) or shifted-out MSB (SHL).
  always_comb begin
    w_res = '0;
    case (r_op)
      OP_LOAD: w_res = {1'b0, r_imm};
      OP_MOV:  w_res = {1'b0, w_b};
      OP_ADD:  w_res = {1'b0, w_a} + {1'b0, w_b};
      OP_SUB:  w_res = {1'b0, w_a} - {1'b0, w_b};
      OP_AND:  w_res = {1'b0, w_a & w_b};
      OP_OR:   w_res = {1'b0, w_a | w_b};
`ifdef PROC_SHIFT_EN
      OP_X110: w_res = {w_a, 1'b0};
`else
      OP_X110: w_res = {1'b0, w_a ^ w_b};
`endif
      OP_OUT:  w_res = {1'b0, w_a};
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_op        <= '0;
      r_rx        <= '0;
      r_ry        <= '0;
      r_imm       <= '0;
      r_res       <= '0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (instrValid) begin
            r_op    <= func[3+2*REG_AW-1 -: 3];
            r_rx    <= func[2*REG_AW-1 -: REG_AW];
            r_ry    <= func[REG_AW-1:0];
            r_imm   <= dataIn;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_res   <= w_res;
          r_state <= S_WB;
        end
        S_WB: begin
          if (r_op == OP_OUT) begin
            r_data_out  <= r_res[DATA_W-1:0];
            r_out_valid <= 1'b1;
          end else begin
            r_regs[r_rx] <= r_res[DATA_W-1:0];
            r_zero       <= (r_res[DATA_W-1:0] == '0);
            if (r_op != OP_LOAD && r_op != OP_MOV) r_carry <= r_res[DATA_W];
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign instrReady  = (r_state == S_IDLE);
  assign dataOut     = r_data_out;
  assign outValid    = r_out_valid;
  assign zeroFlag    = r_zero;
  assign carryFlag   = r_carry;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_param_simple_processor.sv
// Bench for param_simple_processor (DATA_W=8, NREG=8): instruction table with flag expectations,
// OUT results checked through an expected-data queue, plus handshake and reset-abort sequences.
module tb_param_simple_processor;

  localparam int DATA_W = 8;
  localparam int NREG   = 8;
  localparam int REG_AW = 3;

  logic                  clock;
  logic                  resetn;
  logic [3+2*REG_AW-1:0] func;
  logic [DATA_W-1:0]     dataIn;
  logic                  instrValid;
  logic                  instrReady;
  logic [DATA_W-1:0]     dataOut;
  logic                  outValid;
  logic                  zeroFlag;
  logic                  carryFlag;
  logic [1:0]            dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  param_simple_processor #(.DATA_W(DATA_W), .NREG(NREG)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .func        (func),
    .dataIn      (dataIn),
    .instrValid  (instrValid),
    .instrReady  (instrReady),
    .dataOut     (dataOut),
    .outValid    (outValid),
    .zeroFlag    (zeroFlag),
    .carryFlag   (carryFlag),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every outValid pulse pops one expected dataOut
  logic prev_out_valid = 1'b0;
  always @(negedge clock) begin
    if (outValid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL out_unexpected: outValid=1 dataOut=0x%0h with no OUT pending at %0t", dataOut, $time);
      end else begin
        check("out_data", {24'd0, dataOut}, {24'd0, exp_q.pop_front()});
      end
      if (prev_out_valid) check("out_pulse_width", 32'd2, 32'd1);
    end
    prev_out_valid = outValid;
  end

  // driver
  task automatic wait_ready();
    for (int k = 0; k < 10 && !instrReady; k++) @(negedge clock);
    if (!instrReady) check("ready_timeout", {31'd0, instrReady}, 32'd1);
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry,
                       input logic [DATA_W-1:0] din);
    wait_ready();
    func       = {op, rx, ry};
    dataIn     = din;
    instrValid = 1'b1;
    @(posedge clock);
    #1;
    instrValid = 1'b0;
    func       = $urandom_range(0, 511);
    dataIn     = $urandom_range(0, 255);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
  endtask

  typedef struct {
    logic [2:0]        op;
    logic [2:0]        rx;
    logic [2:0]        ry;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] exp_out;
    logic              exp_z;
    logic              exp_c;
  } vec_t;

  vec_t vecs[24];
  int   nv;

  task automatic add_vec(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry,
                         input logic [DATA_W-1:0] din, input logic [DATA_W-1:0] exp_out,
                         input logic exp_z, input logic exp_c);
    vecs[nv] = '{op, rx, ry, din, exp_out, exp_z, exp_c};
    nv++;
  endtask

  int accepts;

  initial begin
    resetn     = 1'b0;
    instrValid = 1'b0;
    func       = '0;
    dataIn     = '0;
    nv         = 0;

    //       op      rx    ry    din    out    Z  C
    add_vec(3'b111, 3'd5, 3'd0, 8'h00, 8'h00, 0, 0); // OUT R5 after reset
    add_vec(3'b000, 3'd1, 3'd0, 8'hF0, 8'h00, 0, 0); // LOAD R1
    add_vec(3'b000, 3'd2, 3'd0, 8'h20, 8'h00, 0, 0); // LOAD R2
    add_vec(3'b010, 3'd1, 3'd2, 8'h00, 8'h00, 0, 1); // ADD -> 0x10, carry
    add_vec(3'b111, 3'd1, 3'd0, 8'h00, 8'h10, 0, 1); // OUT R1, flags kept
    add_vec(3'b000, 3'd3, 3'd0, 8'h05, 8'h00, 0, 1); // LOAD keeps C
    add_vec(3'b011, 3'd3, 3'd3, 8'h00, 8'h00, 1, 0); // SUB self -> 0
    add_vec(3'b000, 3'd4, 3'd0, 8'h01, 8'h00, 0, 0); // LOAD R4
    add_vec(3'b011, 3'd4, 3'd3, 8'h00, 8'h00, 0, 0); // 1-0
    add_vec(3'b011, 3'd3, 3'd4, 8'h00, 8'h00, 0, 1); // 0-1 -> FF, borrow
    add_vec(3'b111, 3'd3, 3'd0, 8'h00, 8'hFF, 0, 1); // OUT R3
    add_vec(3'b100, 3'd1, 3'd3, 8'h00, 8'h00, 0, 0); // AND -> 0x10
    add_vec(3'b101, 3'd5, 3'd1, 8'h00, 8'h00, 0, 0); // OR  -> 0x10
    add_vec(3'b001, 3'd6, 3'd5, 8'h00, 8'h00, 0, 0); // MOV R6<=R5
    add_vec(3'b111, 3'd6, 3'd0, 8'h00, 8'h10, 0, 0); // OUT R6
    add_vec(3'b000, 3'd7, 3'd0, 8'hC3, 8'h00, 0, 0); // LOAD R7
    add_vec(3'b010, 3'd7, 3'd7, 8'h00, 8'h00, 0, 1); // ADD self -> 0x86, C=MSB
    add_vec(3'b001, 3'd7, 3'd7, 8'h00, 8'h00, 0, 1); // MOV self keeps C
    add_vec(3'b111, 3'd7, 3'd0, 8'h00, 8'h86, 0, 1); // OUT R7
    add_vec(3'b000, 3'd0, 3'd0, 8'h81, 8'h00, 0, 1); // LOAD R0
`ifdef PROC_SHIFT_EN
    add_vec(3'b110, 3'd0, 3'd0, 8'h00, 8'h00, 0, 1); // SHL -> 0x02
    add_vec(3'b111, 3'd0, 3'd0, 8'h00, 8'h02, 0, 1);
`else
    add_vec(3'b110, 3'd0, 3'd0, 8'h00, 8'h00, 1, 0); // XOR self -> 0
    add_vec(3'b111, 3'd0, 3'd0, 8'h00, 8'h00, 1, 0);
`endif

    repeat (2) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    check("rst_dataOut", {24'd0, dataOut}, 32'd0);
    check("rst_outValid", {31'd0, outValid}, 32'd0);
    check("rst_zero", {31'd0, zeroFlag}, 32'd0);
    check("rst_carry", {31'd0, carryFlag}, 32'd0);
    check("rst_ready", {31'd0, instrReady}, 32'd1);
    check("rst_state", {30'd0, dbg_state}, 32'd0);

    for (int i = 0; i < nv; i++) begin
      if (vecs[i].op == 3'b111) exp_q.push_back(vecs[i].exp_out);
      issue(vecs[i].op, vecs[i].rx, vecs[i].ry, vecs[i].din);
      check($sformatf("vec%0d_zero", i), {31'd0, zeroFlag}, {31'd0, vecs[i].exp_z});
      check($sformatf("vec%0d_carry", i), {31'd0, carryFlag}, {31'd0, vecs[i].exp_c});
    end

    // Held instrValid with stable OUT R1 (R1=0x10): accepts every third cycle.
    wait_ready();
    func       = {3'b111, 3'd1, 3'd0};
    dataIn     = 8'h00;
    instrValid = 1'b1;
    accepts    = 0;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("hold_ready_%0d", i), {31'd0, instrReady}, {31'd0, (i % 3 == 0)});
      if (instrReady) begin
        accepts++;
        exp_q.push_back(8'h10);
      end
      @(negedge clock);
    end
    instrValid = 1'b0;
    check("hold_accepts", accepts, 32'd3);
    repeat (3) @(negedge clock);

    // Reset while LOAD R6<=AA is in EXEC: nothing may be written.
    wait_ready();
    func       = {3'b000, 3'd6, 3'd0};
    dataIn     = 8'hAA;
    instrValid = 1'b1;
    @(negedge clock);
    instrValid = 1'b0;
    check("abort_in_exec", {30'd0, dbg_state}, 32'd1);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    check("abort_ready", {31'd0, instrReady}, 32'd1);
    check("abort_zero", {31'd0, zeroFlag}, 32'd0);
    repeat (3) @(negedge clock);
    exp_q.push_back(8'h00);
    issue(3'b111, 3'd6, 3'd0, 8'h00);

    // Reset on the WB edge of an OUT: the pulse must be suppressed.
    issue(3'b000, 3'd2, 3'd0, 8'h5A);
    wait_ready();
    func       = {3'b111, 3'd2, 3'd0};
    instrValid = 1'b1;
    @(negedge clock);
    instrValid = 1'b0;
    @(negedge clock);
    check("abort_in_wb", {30'd0, dbg_state}, 32'd2);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    check("abort_wb_dataOut", {24'd0, dataOut}, 32'd0);
    repeat (3) @(negedge clock);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
